// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART receive path.
package uart_pkg;
    localparam int NBITS = 8;
    localparam int BIDX_W = $clog2(NBITS);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
endpackage

// File: rtl/uart_rx_frame_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, reset to a chosen level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with mid-bit sampling, false-start rejection,
// framing-error strobe and line-break recovery.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RXD,
    output logic [NBITS-1:0] DATA,
    output logic             EN,
    output logic             FERR,
    output logic             BUSY
);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    if (CLKS_PER_BIT < 4) begin : g_bad_param
        $error("uart_rx_frame: CLKS_PER_BIT must be >= 4");
    end
    logic              rx_s;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BIDX_W-1:0] bit_idx, bit_idx_nx;
    logic [NBITS-1:0]  shreg, shreg_nx, data_nx;
    logic              en_nx, ferr_nx;
    sync2 #(.RST_VAL(1'b1)) u_sync (.clk(CLK), .rst(RST), .d(RXD), .q(rx_s));
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            DATA    <= '0;
            EN      <= 1'b0;
            FERR    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
            DATA    <= data_nx;
            EN      <= en_nx;
            FERR    <= ferr_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        data_nx    = DATA;
        en_nx      = 1'b0;
        ferr_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = ST_START;
            end
            // a start bit that is gone by mid-bit is a glitch
            ST_START: if (cnt == HALF) begin
                cnt_nx     = '0;
                bit_idx_nx = '0;
                state_nx   = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt == FULL) begin
                cnt_nx     = '0;
                bit_idx_nx = bit_idx + BIDX_W'(1);
                shreg_nx   = {rx_s, shreg[NBITS-1:1]};
                if (bit_idx == BIDX_W'(NBITS - 1)) state_nx = ST_STOP;
            end
            // leaving at mid stop bit lets a zero-gap start edge be caught
            ST_STOP: if (cnt == FULL) begin
                cnt_nx   = '0;
                en_nx    = rx_s;
                ferr_nx  = !rx_s;
                data_nx  = rx_s ? shreg : DATA;
                state_nx = rx_s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                cnt_nx = '0;
                if (rx_s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    assign BUSY = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed vectors plus hand-written corner sequences at CLKS_PER_BIT=8.
module tb_uart_rx_frame;
    localparam int CPB = 8;
    localparam int BIT = 800;
    logic       clk, rst, rxd;
    logic [7:0] data;
    logic       en, ferr, busy;
    int         cyc = 0;
    int         n_chk = 0, n_pass = 0;
    int         ferr_n = 0, both_n = 0;
    int         fall_cyc;
    logic [7:0] en_q[$];
    int         en_t[$];

    uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(clk), .RST(rst), .RXD(rxd), .DATA(data), .EN(en), .FERR(ferr), .BUSY(busy)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (en) begin
            en_q.push_back(data);
            en_t.push_back(cyc);
        end
        if (ferr) ferr_n++;
        if (en && ferr) both_n++;
    end

    typedef struct {
        logic [7:0] b;
        int         bitp;
        bit         chk_lat;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int bitp, input bit align);
        if (align) begin
            @(posedge clk);
            #1;
        end
        fall_cyc = cyc;
        rxd = 1'b0;
        #bitp;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #bitp;
        end
        rxd = stop;
        #bitp;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        #n;
    endtask

    vec_t vecs[4];
    int   e0, f0, lat;

    initial begin
        vecs[0] = '{8'hA5, 800, 1'b1, 8'hA5};
        vecs[1] = '{8'hC3, 825, 1'b0, 8'hC3};
        vecs[2] = '{8'hC3, 775, 1'b0, 8'hC3};
        vecs[3] = '{8'h5A, 800, 1'b1, 8'h5A};
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_en", en, 0);
        check("reset_ferr", ferr, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(2 * BIT);

        foreach (vecs[k]) begin
            e0 = en_q.size();
            f0 = ferr_n;
            send(vecs[k].b, 1'b1, vecs[k].bitp, 1'b1);
            idle(2 * BIT);
            check($sformatf("vec%0d_en_count", k), en_q.size() - e0, 1);
            check($sformatf("vec%0d_ferr_count", k), ferr_n - f0, 0);
            check($sformatf("vec%0d_data", k), data, vecs[k].exp);
            if (vecs[k].chk_lat && en_q.size() > e0) begin
                lat = en_t[e0] - fall_cyc;
                check($sformatf("vec%0d_latency_%0d", k, lat), (lat >= 78 && lat <= 80), 1);
            end
        end

        // short low pulse must be rejected as a false start
        e0 = en_q.size();
        f0 = ferr_n;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_low", busy, 0);
        idle(2 * BIT);
        check("glitch_no_en", en_q.size() - e0, 0);
        check("glitch_no_ferr", ferr_n - f0, 0);
        send(8'h3C, 1'b1, BIT, 1'b1);
        idle(2 * BIT);
        check("after_glitch_en", en_q.size() - e0, 1);
        check("after_glitch_data", data, 8'h3C);

        // framing error followed by a long break
        e0 = en_q.size();
        f0 = ferr_n;
        send(8'h11, 1'b0, BIT, 1'b1);
        #(2 * BIT);
        check("ferr_once", ferr_n - f0, 1);
        check("ferr_no_en", en_q.size() - e0, 0);
        check("ferr_data_kept", data, 8'h3C);
        #(18 * BIT);
        check("break_busy", busy, 1);
        check("break_single_ferr", ferr_n - f0, 1);
        idle(2 * BIT);
        check("break_exit_idle", busy, 0);
        send(8'h3C, 1'b1, BIT, 1'b1);
        idle(2 * BIT);
        check("after_break_en", en_q.size() - e0, 1);
        check("after_break_data", data, 8'h3C);
        check("after_break_ferr", ferr_n - f0, 1);

        // three frames with zero idle gap
        e0 = en_q.size();
        send(8'h00, 1'b1, BIT, 1'b1);
        send(8'hFF, 1'b1, BIT, 1'b0);
        send(8'h55, 1'b1, BIT, 1'b0);
        idle(2 * BIT);
        check("b2b_en_count", en_q.size() - e0, 3);
        if (en_q.size() - e0 == 3) begin
            check("b2b_data0", en_q[e0], 8'h00);
            check("b2b_data1", en_q[e0+1], 8'hFF);
            check("b2b_data2", en_q[e0+2], 8'h55);
            check("b2b_gap01", en_t[e0+1] - en_t[e0], 80);
            check("b2b_gap12", en_t[e0+2] - en_t[e0+1], 80);
        end

        // asynchronous reset during bit 4 discards the partial frame
        @(posedge clk);
        #1;
        rxd = 1'b0;
        #BIT;
        for (int i = 0; i < 4; i++) begin
            rxd = i[0] ? 1'b1 : 1'b0;
            #BIT;
        end
        #(BIT / 2);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_data", data, 8'h00);
        check("async_rst_busy", busy, 0);
        check("async_rst_en", en, 0);
        check("async_rst_ferr", ferr, 0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        idle(2 * BIT);
        e0 = en_q.size();
        send(8'h7E, 1'b1, BIT, 1'b1);
        idle(2 * BIT);
        check("post_rst_en", en_q.size() - e0, 1);
        check("post_rst_data", data, 8'h7E);
        check("never_en_and_ferr", both_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
